// File: rtl/mul_seq12_ctrl_if.sv
// Operand/result valid-ready bundle for the 12x12 multiply sequencer.
// The sequencer uses the slave modport; the producer/consumer side uses master.
interface mul_seq12_ctrl_if #(
  parameter int DATA_W = 12
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   b;
  logic                out_valid;
  logic                out_ready;
  logic [2*DATA_W-1:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/mul_seq12_ctrl.sv
// Multi-cycle 12x12 unsigned multiply sequencer around an external 8x8 array multiplier.
// Optional macro MUL_SEQ12_ZERO_SKIP_EN: a zero operand jumps straight to DONE with product 0.
module mul_seq12_ctrl #(
  parameter int DATA_W  = 12,
  parameter int SLICE_W = 6,
  parameter int MUL_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  mul_seq12_ctrl_if.slave    bus,
  output logic [MUL_W-1:0]   mul_a,
  output logic [MUL_W-1:0]   mul_b,
  input  logic [2*MUL_W-1:0] mul_p
);
  localparam int ACC_W   = 2 * DATA_W;
  localparam int SHIFT_W = $clog2(ACC_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    a_q, a_d;
  logic [DATA_W-1:0]    b_q, b_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACC_W-1:0]     product_q, product_d;
  logic [1:0]           step_q, step_d;

  logic [SLICE_W-1:0]   a_sl_s, b_sl_s;
  logic [SHIFT_W-1:0]   shift_s;
  logic [ACC_W-1:0]     partial_s;
  logic [ACC_W-1:0]     acc_sum_s;
  logic                 zero_op_s;

`ifdef MUL_SEQ12_ZERO_SKIP_EN
  assign zero_op_s = (bus.a == '0) || (bus.b == '0);
`else
  assign zero_op_s = 1'b0;
`endif

  // Slice pair and weight for the current step: LL, LH, HL, HH.
  always_comb begin
    a_sl_s  = '0;
    b_sl_s  = '0;
    shift_s = '0;
    case (step_q)
      2'd0: begin
        a_sl_s  = a_q[SLICE_W-1:0];
        b_sl_s  = b_q[SLICE_W-1:0];
        shift_s = '0;
      end
      2'd1: begin
        a_sl_s  = a_q[SLICE_W-1:0];
        b_sl_s  = b_q[DATA_W-1:SLICE_W];
        shift_s = SHIFT_W'(SLICE_W);
      end
      2'd2: begin
        a_sl_s  = a_q[DATA_W-1:SLICE_W];
        b_sl_s  = b_q[SLICE_W-1:0];
        shift_s = SHIFT_W'(SLICE_W);
      end
      2'd3: begin
        a_sl_s  = a_q[DATA_W-1:SLICE_W];
        b_sl_s  = b_q[DATA_W-1:SLICE_W];
        shift_s = SHIFT_W'(2 * SLICE_W);
      end
      default: begin
        a_sl_s  = '0;
        b_sl_s  = '0;
        shift_s = '0;
      end
    endcase
  end

  assign partial_s = ACC_W'(mul_p) << shift_s;
  assign acc_sum_s = acc_q + partial_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = zero_op_s ? DONE : BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (step_q == 2'd3) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand latch, accumulation and result capture.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    step_d    = step_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d    = bus.a;
          b_d    = bus.b;
          acc_d  = '0;
          step_d = 2'd0;
          if (zero_op_s) begin
            product_d = '0;
          end else begin
            product_d = product_q;
          end
        end else begin
          a_d = a_q;
        end
      end
      BUSY: begin
        acc_d  = acc_sum_s;
        step_d = step_q + 2'd1;
        // The last partial product lands directly in the result register.
        if (step_q == 2'd3) begin
          product_d = acc_sum_s;
        end else begin
          product_d = product_q;
        end
      end
      DONE: begin
        product_d = product_q;
      end
      default: begin
        acc_d  = '0;
        step_d = 2'd0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      step_q    <= 2'd0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      product_q <= product_d;
    end
  end

  // Handshake flags and multiplier drive, all decoded from the state register.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    mul_a         = '0;
    mul_b         = '0;
    case (state_q)
      IDLE: bus.in_ready = 1'b1;
      BUSY: begin
        mul_a = MUL_W'(a_sl_s);
        mul_b = MUL_W'(b_sl_s);
      end
      DONE: bus.out_valid = 1'b1;
      default: begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
      end
    endcase
  end

  assign bus.product = product_q;
endmodule

// File: tb/tb_mul_seq12_ctrl.sv
// Self-checking bench for mul_seq12_ctrl: vector table plus a few reset/backpressure sequences,
// with an expected-result queue popped on each result handshake.
module tb_mul_seq12_ctrl;
  localparam int DATA_W  = 12;
  localparam int SLICE_W = 6;
  localparam int MUL_W   = 8;
`ifdef MUL_SEQ12_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [MUL_W-1:0]   mul_a;
  logic [MUL_W-1:0]   mul_b;
  logic [2*MUL_W-1:0] mul_p;

  mul_seq12_ctrl_if #(.DATA_W(DATA_W)) bus ();

  // Behavioural stand-in for the 8x8 array multiplier.
  assign mul_p = {8'd0, mul_a} * {8'd0, mul_b};

  mul_seq12_ctrl #(.DATA_W(DATA_W), .SLICE_W(SLICE_W), .MUL_W(MUL_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [23:0] exp;
    int          stall;
    bit          pulse;
  } vec_t;

  vec_t        vecs[8];
  logic [23:0] sb_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [11:0] a, input logic [11:0] b, input logic [23:0] exp,
                        input int stall, input bit pulse);
    int          lat;
    int          exp_lat;
    logic [23:0] want;
    logic [5:0]  ea;
    logic [5:0]  eb;
    exp_lat = (ZERO_SKIP && (a == 12'd0 || b == 12'd0)) ? 1 : 5;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    sb_q.push_back(exp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 12'h5A5;
    bus.b        = 12'hA5A;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      if (lat <= 4) begin
        ea = (lat <= 2) ? a[5:0] : a[11:6];
        eb = (lat == 1 || lat == 3) ? b[5:0] : b[11:6];
        chk("mul_a_step", 32'(mul_a), 32'(ea));
        chk("mul_b_step", 32'(mul_b), 32'(eb));
        chk("mul_p_hi_zero", 32'(mul_p[15:12]), 32'd0);
      end
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      bus.in_valid = pulse;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    if (!bus.out_valid) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb_q.delete();
    end else begin
      for (int s = 0; s < stall; s++) begin
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_product", 32'(bus.product), 32'(exp));
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = pulse;
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
      chk("done_mul_a", 32'(mul_a), 32'd0);
      bus.out_ready = 1'b1;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: result with no expected entry, product 0x%0h", bus.product);
      end else begin
        want = sb_q.pop_front();
        chk("product", 32'(bus.product), 32'(want));
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("out_valid_drop", 32'(bus.out_valid), 32'd0);
      chk("in_ready_back", 32'(bus.in_ready), 32'd1);
      chk("product_kept", 32'(bus.product), 32'(exp));
    end
  endtask

  initial begin
    logic [11:0] ra;
    logic [11:0] rb;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 12'd0;
    bus.b         = 12'd0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    rst = 1'b0;

    vecs[0] = '{12'h003, 12'h005, 24'h00000F, 0, 1'b0};
    vecs[1] = '{12'hFFF, 12'hFFF, 24'hFFE001, 0, 1'b0};
    vecs[2] = '{12'h040, 12'h800, 24'h020000, 3, 1'b1};
    vecs[3] = '{12'h000, 12'h123, 24'h000000, 0, 1'b0};
    vecs[4] = '{12'h123, 12'h456, 24'h04EDC2, 1, 1'b0};
    vecs[5] = '{12'hABC, 12'h001, 24'h000ABC, 0, 1'b0};
    vecs[6] = '{12'h001, 12'hFFF, 24'h000FFF, 2, 1'b1};
    vecs[7] = '{12'h03F, 12'h040, 24'h000FC0, 0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall, vecs[i].pulse);
    end

    for (int i = 0; i < 6; i++) begin
      ra = 12'($urandom_range(0, 4095));
      rb = 12'($urandom_range(1, 4095));
      run_op(ra, rb, 24'(ra) * 24'(rb), int'($urandom_range(0, 2)), 1'b0);
    end

    // Reset while step 2 is on the multiplier: the operation must vanish.
    bus.in_valid = 1'b1;
    bus.a        = 12'h0AB;
    bus.b        = 12'h0CD;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midop_step2_mul_a", 32'(mul_a), 32'd2);
    chk("midop_step2_mul_b", 32'(mul_b), 32'd13);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midop_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midop_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midop_product", 32'(bus.product), 32'd0);
    chk("midop_mul_a", 32'(mul_a), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("midop_no_result", 32'(bus.out_valid), 32'd0);
    end
    run_op(12'h123, 12'h456, 24'h04EDC2, 0, 1'b0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
